// File: rtl/axi_lite_cmd_master_if.sv
// Command/response port and AXI-Lite bus bundles for axi_lite_cmd_master.
// Widths follow the master's ADDR_W / Data_W parameters.
interface axi_lite_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int Data_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [Data_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [Data_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  busy
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output busy
    );
endinterface

interface axi_lite_bus_if #(
    parameter int ADDR_W = 32,
    parameter int Data_W = 32
);
    logic              R_Valid_Address;
    logic              R_Ready_Address;
    logic [ADDR_W-1:0] Read_Address_axi;
    logic [2:0]        R_Prot;
    logic              Read_Ready;
    logic              Valid_Data_R;
    logic [Data_W-1:0] Read_Data_axi;
    logic              R_Error;
    logic              Write_Valid;
    logic [ADDR_W-1:0] Write_Address_axi;
    logic [Data_W-1:0] Write_Data_axi;
    logic [3:0]        Write_Strobe;
    logic [2:0]        W_Prot;
    logic              Write_Ready;
    logic              W_Error;

    modport master (
        output R_Valid_Address, Read_Address_axi, R_Prot, Read_Ready,
        input  R_Ready_Address, Valid_Data_R, Read_Data_axi, R_Error,
        output Write_Valid, Write_Address_axi, Write_Data_axi,
        output Write_Strobe, W_Prot,
        input  Write_Ready, W_Error
    );
    modport slave (
        input  R_Valid_Address, Read_Address_axi, R_Prot, Read_Ready,
        output R_Ready_Address, Valid_Data_R, Read_Data_axi, R_Error,
        input  Write_Valid, Write_Address_axi, Write_Data_axi,
        input  Write_Strobe, W_Prot,
        output Write_Ready, W_Error
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI-Lite initiator: one bus transaction per command, one outstanding.
// Optional stall abort enabled by defining AXIM_TIMEOUT_EN.
module axi_lite_cmd_master #(
    parameter int         ADDR_W         = 32,
    parameter int         Data_W         = 32,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input logic                  Clk_axi,
    input logic                  Rst,
    axi_lite_cmd_master_if.slave cmd,
    axi_lite_bus_if.master       bus
);
    typedef enum logic [2:0] {
        IDLE, WR_REQ, RD_ADDR, RD_DATA, RESP
    } state_e;

    state_e            state_q, state_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [Data_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [Data_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

`ifdef AXIM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    always_ff @(posedge Clk_axi) begin
        if (Rst) begin
            state_q   <= IDLE;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef AXIM_TIMEOUT_EN
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef AXIM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef AXIM_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    addr_d  = cmd.cmd_addr;
                    wdata_d = cmd.cmd_wdata;
                    wstrb_d = cmd.cmd_wstrb;
`ifdef AXIM_TIMEOUT_EN
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
`endif
                    if (cmd.cmd_write) begin
                        wvalid_d = 1'b1;
                        state_d  = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_REQ: begin
                if (bus.Write_Ready) begin
                    wvalid_d = 1'b0;
                    err_d    = bus.W_Error;
                    rdata_d  = '0;
                    state_d  = RESP;
                end
            end
            RD_ADDR: begin
                if (bus.R_Ready_Address) begin
                    arvalid_d = 1'b0;
                    // Address and data may complete on the same edge
                    if (bus.Valid_Data_R) begin
                        rdata_d  = bus.Read_Data_axi;
                        err_d    = bus.R_Error;
                        rready_d = 1'b0;
                        state_d  = RESP;
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end
            RD_DATA: begin
                if (bus.Valid_Data_R) begin
                    rdata_d  = bus.Read_Data_axi;
                    err_d    = bus.R_Error;
                    rready_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (cmd.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXIM_TIMEOUT_EN
        // A completing handshake on the expiry edge takes priority
        if ((state_q == WR_REQ || state_q == RD_ADDR ||
             state_q == RD_DATA) && state_d != RESP) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                err_d     = 1'b1;
                tmo_d     = 1'b1;
                rdata_d   = '0;
                state_d   = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign cmd.rsp_valid = (state_q == RESP);
    assign cmd.busy      = (state_q != IDLE);
    assign cmd.rsp_rdata = rdata_q;
    assign cmd.rsp_err   = err_q;
`ifdef AXIM_TIMEOUT_EN
    assign cmd.rsp_timeout = tmo_q;
`else
    assign cmd.rsp_timeout = 1'b0;
`endif

    assign bus.R_Valid_Address   = arvalid_q;
    assign bus.Read_Address_axi  = addr_q;
    assign bus.R_Prot            = PROT;
    assign bus.Read_Ready        = rready_q;
    assign bus.Write_Valid       = wvalid_q;
    assign bus.Write_Address_axi = addr_q;
    assign bus.Write_Data_axi    = wdata_q;
    assign bus.Write_Strobe      = wstrb_q;
    assign bus.W_Prot            = PROT;
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master; bus slave driven from tasks.
// Timeout scenario checks abort when AXIM_TIMEOUT_EN is defined, else stall.
module tb_axi_lite_cmd_master;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    axi_lite_cmd_master_if #(.ADDR_W(32), .Data_W(32)) cif ();
    axi_lite_bus_if        #(.ADDR_W(32), .Data_W(32)) bif ();

    axi_lite_cmd_master #(
        .ADDR_W(32),
        .Data_W(32),
        .PROT(3'b000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .Clk_axi(clk),
        .Rst(rst),
        .cmd(cif.slave),
        .bus(bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cif.cmd_valid = 1'b1;
        cif.cmd_write = wr;
        cif.cmd_addr  = a;
        cif.cmd_wdata = d;
        cif.cmd_wstrb = s;
        tick();
        cif.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cif.cmd_ready); end
        total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", cif.busy); end
        total++; if (cif.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", cif.rsp_valid); end
        total++; if ({bif.Write_Valid, bif.R_Valid_Address, bif.Read_Ready} !== 3'b000) begin bad++; $display("FAIL rst_valids got=%b exp=000", {bif.Write_Valid, bif.R_Valid_Address, bif.Read_Ready}); end
        total++; if (bif.Write_Address_axi !== 32'h0 || bif.Write_Strobe !== 4'h0) begin bad++; $display("FAIL rst_payload got=%h/%h exp=0/0", bif.Write_Address_axi, bif.Write_Strobe); end
        total++; if (cif.rsp_rdata !== 32'h0 || cif.rsp_err !== 1'b0 || cif.rsp_timeout !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b/%b exp=0/0/0", cif.rsp_rdata, cif.rsp_err, cif.rsp_timeout); end
    endtask

    task automatic test_write();
        issue(1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF);
        for (int i = 0; i < 2; i++) begin
            total++; if (bif.Write_Valid !== 1'b1) begin bad++; $display("FAIL wr_valid_%0d got=%b exp=1", i, bif.Write_Valid); end
            total++; if (bif.Write_Address_axi !== 32'h4 || bif.Write_Data_axi !== 32'hA5A5_1234 || bif.Write_Strobe !== 4'hF) begin bad++; $display("FAIL wr_payload_%0d got=%h/%h/%h exp=4/a5a51234/f", i, bif.Write_Address_axi, bif.Write_Data_axi, bif.Write_Strobe); end
            total++; if (cif.cmd_ready !== 1'b0 || cif.busy !== 1'b1) begin bad++; $display("FAIL wr_busy_%0d got=%b/%b exp=0/1", i, cif.cmd_ready, cif.busy); end
            if (i == 1) begin
                bif.Write_Ready = 1'b1;
                bif.W_Error     = 1'b0;
            end
            tick();
        end
        bif.Write_Ready = 1'b0;
        total++; if (bif.Write_Valid !== 1'b0) begin bad++; $display("FAIL wr_drop got=%b exp=0", bif.Write_Valid); end
        total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_err !== 1'b0 || cif.rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/0", cif.rsp_valid, cif.rsp_err, cif.rsp_rdata); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        total++; if (cif.rsp_valid !== 1'b0 || cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_idle got=%b/%b exp=0/1", cif.rsp_valid, cif.cmd_ready); end
    endtask

    task automatic test_read();
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            total++; if (bif.R_Valid_Address !== 1'b1 || bif.Read_Address_axi !== 32'h10 || bif.Read_Ready !== 1'b1) begin bad++; $display("FAIL rd_addr_%0d got=%b/%h/%b exp=1/10/1", i, bif.R_Valid_Address, bif.Read_Address_axi, bif.Read_Ready); end
            if (i == 3) bif.R_Ready_Address = 1'b1;
            tick();
        end
        bif.R_Ready_Address = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if (bif.R_Valid_Address !== 1'b0 || bif.Read_Ready !== 1'b1 || cif.rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_wait_%0d got=%b/%b/%b exp=0/1/0", i, bif.R_Valid_Address, bif.Read_Ready, cif.rsp_valid); end
            if (i == 1) begin
                bif.Valid_Data_R  = 1'b1;
                bif.Read_Data_axi = 32'hDEAD_BEEF;
                bif.R_Error       = 1'b0;
            end
            tick();
        end
        bif.Valid_Data_R  = 1'b0;
        bif.Read_Data_axi = 32'h0;
        total++; if (bif.Read_Ready !== 1'b0) begin bad++; $display("FAIL rd_rready_drop got=%b exp=0", bif.Read_Ready); end
        total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_rdata !== 32'hDEAD_BEEF || cif.rsp_err !== 1'b0) begin bad++; $display("FAIL rd_rsp got=%b/%h/%b exp=1/deadbeef/0", cif.rsp_valid, cif.rsp_rdata, cif.rsp_err); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        total++; if (cif.busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b exp=0", cif.busy); end
    endtask

    task automatic test_read_same_cycle(input logic [31:0] d, input logic e);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        total++; if (bif.R_Valid_Address !== 1'b1) begin bad++; $display("FAIL rs_addr got=%b exp=1", bif.R_Valid_Address); end
        bif.R_Ready_Address = 1'b1;
        bif.Valid_Data_R    = 1'b1;
        bif.Read_Data_axi   = d;
        bif.R_Error         = e;
        tick();
        bif.R_Ready_Address = 1'b0;
        bif.Valid_Data_R    = 1'b0;
        bif.R_Error         = 1'b0;
        total++; if (bif.R_Valid_Address !== 1'b0 || bif.Read_Ready !== 1'b0) begin bad++; $display("FAIL rs_drop got=%b/%b exp=0/0", bif.R_Valid_Address, bif.Read_Ready); end
        total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_rdata !== d || cif.rsp_err !== e) begin bad++; $display("FAIL rs_rsp got=%b/%h/%b exp=1/%h/%b", cif.rsp_valid, cif.rsp_rdata, cif.rsp_err, d, e); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 32'h0000_0008, 32'h1, 4'h3);
        bif.Write_Ready = 1'b1;
        bif.W_Error     = 1'b1;
        tick();
        bif.Write_Ready = 1'b0;
        bif.W_Error     = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_write = 1'b0;
        cif.cmd_addr  = 32'h0000_0030;
        for (int i = 0; i < 5; i++) begin
            total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_err !== 1'b1 || cif.cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_%0d got=%b/%b/%b exp=1/1/0", i, cif.rsp_valid, cif.rsp_err, cif.cmd_ready); end
            tick();
        end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        total++; if (cif.cmd_ready !== 1'b1 || bif.R_Valid_Address !== 1'b0) begin bad++; $display("FAIL b2b_noaccept got=%b/%b exp=1/0", cif.cmd_ready, bif.R_Valid_Address); end
        tick();
        cif.cmd_valid = 1'b0;
        total++; if (bif.R_Valid_Address !== 1'b1 || bif.Read_Address_axi !== 32'h30) begin bad++; $display("FAIL b2b_accept got=%b/%h exp=1/30", bif.R_Valid_Address, bif.Read_Address_axi); end
        bif.R_Ready_Address = 1'b1;
        bif.Valid_Data_R    = 1'b1;
        bif.Read_Data_axi   = 32'h1234_5678;
        bif.R_Error         = 1'b1;
        tick();
        bif.R_Ready_Address = 1'b0;
        bif.Valid_Data_R    = 1'b0;
        bif.R_Error         = 1'b0;
        total++; if (cif.rsp_rdata !== 32'h1234_5678 || cif.rsp_err !== 1'b1) begin bad++; $display("FAIL b2b_rsp got=%h/%b exp=12345678/1", cif.rsp_rdata, cif.rsp_err); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        bif.R_Ready_Address = 1'b1;
        tick();
        bif.R_Ready_Address = 1'b0;
        total++; if (bif.Read_Ready !== 1'b1 || bif.R_Valid_Address !== 1'b0) begin bad++; $display("FAIL rm_rddata got=%b/%b exp=1/0", bif.Read_Ready, bif.R_Valid_Address); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({bif.Write_Valid, bif.R_Valid_Address, bif.Read_Ready} !== 3'b000) begin bad++; $display("FAIL rm_valids got=%b exp=000", {bif.Write_Valid, bif.R_Valid_Address, bif.Read_Ready}); end
        total++; if (cif.rsp_valid !== 1'b0 || cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_state got=%b/%b exp=0/1", cif.rsp_valid, cif.cmd_ready); end
        bif.Valid_Data_R  = 1'b1;
        bif.Read_Data_axi = 32'hCAFE_0001;
        tick();
        bif.Valid_Data_R = 1'b0;
        total++; if (cif.rsp_valid !== 1'b0 || cif.busy !== 1'b0) begin bad++; $display("FAIL rm_noresp got=%b/%b exp=0/0", cif.rsp_valid, cif.busy); end
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b1, 32'h0000_0050, 32'h77, 4'hF);
`ifdef AXIM_TIMEOUT_EN
        n = 0;
        while (bif.Write_Valid === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        total++; if (n !== 8) begin bad++; $display("FAIL to_len got=%0d exp=8", n); end
        total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_err !== 1'b1 || cif.rsp_timeout !== 1'b1 || cif.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_rsp got=%b/%b/%b/%h exp=1/1/1/0", cif.rsp_valid, cif.rsp_err, cif.rsp_timeout, cif.rsp_rdata); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
        issue(1'b1, 32'h0000_0054, 32'h78, 4'hF);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) bif.Write_Ready = 1'b1;
            tick();
        end
        bif.Write_Ready = 1'b0;
        total++; if (cif.rsp_valid !== 1'b1 || cif.rsp_timeout !== 1'b0 || cif.rsp_err !== 1'b0) begin bad++; $display("FAIL to_race got=%b/%b/%b exp=1/0/0", cif.rsp_valid, cif.rsp_timeout, cif.rsp_err); end
        cif.rsp_ready = 1'b1;
        tick();
        cif.rsp_ready = 1'b0;
`else
        n = 0;
        for (int i = 0; i < 120; i++) begin
            if (cif.busy === 1'b1 && bif.Write_Valid === 1'b1) n++;
            tick();
        end
        total++; if (n !== 120) begin bad++; $display("FAIL stall_busy got=%0d exp=120", n); end
        total++; if (cif.rsp_valid !== 1'b0 || cif.rsp_timeout !== 1'b0) begin bad++; $display("FAIL stall_rsp got=%b/%b exp=0/0", cif.rsp_valid, cif.rsp_timeout); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        total++; if (cif.cmd_ready !== 1'b1) begin bad++; $display("FAIL to_idle got=%b exp=1", cif.cmd_ready); end
    endtask

    initial begin
        rst                 = 1'b1;
        cif.cmd_valid       = 1'b0;
        cif.cmd_write       = 1'b0;
        cif.cmd_addr        = '0;
        cif.cmd_wdata       = '0;
        cif.cmd_wstrb       = '0;
        cif.rsp_ready       = 1'b0;
        bif.R_Ready_Address = 1'b0;
        bif.Valid_Data_R    = 1'b0;
        bif.Read_Data_axi   = '0;
        bif.R_Error         = 1'b0;
        bif.Write_Ready     = 1'b0;
        bif.W_Error         = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_read_same_cycle(32'h0000_00FF, 1'b0);
        test_back_to_back();
        test_rst_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI-Lite initiator that drives the USB host controller's AXI slave port on the CPU/testbench side, on the same Clk_axi domain.
- Accepts single read/write commands on a valid/ready command port and runs one AXI-Lite transaction per command.
- Returns read data and error status on a valid/ready response port.
- Lets firmware-model logic or a sequencer program the UHCI register file and descriptor memory without hand-driving bus pins.

Parameters:
ADDR_W, 32, address width
Data_W, 32, data width
PROT, 3'b000, constant driven on R_Prot/W_Prot
TIMEOUT_CYCLES, 256, cycles a transaction may stall before abort (used only with AXIM_TIMEOUT_EN); must be >= 2

Ports:
Clk_axi  in  1  single clock; all logic rising-edge
Rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  Data_W  write data
cmd_wstrb  in  4  byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at edge
rsp_rdata  out  Data_W  read data (0 for writes)
rsp_err  out  1  slave error or timeout
rsp_timeout  out  1  transaction aborted by timeout
busy  out  1  state != IDLE
R_Valid_Address  out  1  read address valid
R_Ready_Address  in  1  slave accepts read address
Read_Address_axi  out  ADDR_W  read address
R_Prot  out  3  = PROT
Read_Ready  out  1  master ready for read data
Valid_Data_R  in  1  read data valid
Read_Data_axi  in  Data_W  read data
R_Error  in  1  read error, sampled with Valid_Data_R
Write_Valid  out  1  write address+data+strobe valid
Write_Address_axi  out  ADDR_W  write address
Write_Data_axi  out  Data_W  write data
Write_Strobe  out  4  write strobes
W_Prot  out  3  = PROT
Write_Ready  in  1  slave accepts write
W_Error  in  1  write error, sampled with Write_Ready

Behaviour:
- Reset values:
  - State IDLE; all bus valids/readies 0; addresses, data and strobes 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0.
  - cmd_ready=1, since cmd_ready is a combinational decode of state==IDLE.
- FSM states: IDLE, WR_REQ, RD_ADDR, RD_DATA, RESP. All bus outputs are registered.
- IDLE:
  - On cmd accept, latch addr/data/strb.
  - cmd_write=1: go to WR_REQ with Write_Valid=1 from the next cycle.
  - cmd_write=0: go to RD_ADDR with R_Valid_Address=1 and Read_Ready=1 from the next cycle.
- WR_REQ:
  - Hold Write_Valid and payload stable until Write_Ready=1 at an edge.
  - On that edge: Write_Valid->0, rsp_err<=W_Error, rsp_rdata<=0, go to RESP.
- RD_ADDR:
  - Hold R_Valid_Address and Read_Address_axi until R_Ready_Address=1.
  - If Valid_Data_R=1 on the same edge: capture Read_Data_axi/R_Error, drop both R_Valid_Address and Read_Ready, go to RESP.
  - Otherwise: drop R_Valid_Address and go to RD_DATA.
- RD_DATA:
  - Read_Ready stays 1 until Valid_Data_R=1.
  - On that edge: rsp_rdata<=Read_Data_axi, rsp_err<=R_Error, Read_Ready->0, go to RESP.
- Valid_Data_R while in WR_REQ or IDLE is ignored.
- RESP:
  - rsp_valid=1; response fields held stable until rsp_ready=1 at an edge.
  - Then rsp_valid->0 and return to IDLE.
  - No new command is accepted in the same cycle as the response handshake.
- Latency, zero-wait slave:
  - Write: accept edge N, Write_Valid high during N+1, rsp_valid high from N+2. The next cmd accept is at N+3 at the earliest if rsp_ready is tied 1.
  - Read: same timing when address and data are accepted in the same cycle.
- Never more than one outstanding transaction; no reordering.
- Rst asserted mid-transaction:
  - All valids drop at the next edge and the pending response is discarded.
  - The slave is reset by the same Rst, so no orphan handshake exists.
- Addresses are passed through unmodified; no alignment checks.

Optional Feature:
AXIM_TIMEOUT_EN
- Defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on cmd accept and increments each cycle in WR_REQ/RD_ADDR/RD_DATA.
  - If it reaches TIMEOUT_CYCLES-1 with no completing handshake on that edge: drop all bus valids/readies, then go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A handshake on the same edge as expiry wins; the response is normal and rsp_timeout=0.
- Undefined: no counter exists, a stalled transaction waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write 0x0000_0004 data 0xA5A5_1234 strb 4'hF, slave Write_Ready 1 cycle after Write_Valid, W_Error=0 -> Write_Valid high exactly 2 cycles with stable payload; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read 0x0000_0010, R_Ready_Address after 3 cycles, Valid_Data_R 2 cycles later with 0xDEAD_BEEF -> R_Valid_Address 4 cycles, Read_Ready held until data; rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Read where R_Ready_Address and Valid_Data_R coincide, data 0x0000_00FF -> RD_DATA skipped; rsp_valid 1 cycle later with 0x0000_00FF.
- Write with W_Error=1; hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_err=1 held 5 cycles, cmd_ready=0 throughout; IDLE after rsp_ready.
- Rst pulse 1 cycle while in RD_DATA -> next edge all valids 0, rsp_valid=0, cmd_ready=1; no response emitted.
- AXIM_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds to a write -> Write_Valid drops after 8 cycles; rsp_err=1, rsp_timeout=1. Without the macro, busy stays 1 for 100+ cycles.
